// File: rtl/topk_input_loader.sv
// -----------------------------------------------------------------------------
// topk_input_loader
//
// Collects one frame of up to MAX_DATALENGTH elements from a serial
// valid/ready stream into a parallel buffer. That buffer is then handed to
// the top-k sorter in a single transfer.
//
// A frame starts with a configuration handshake that carries:
//   - the element signedness;
//   - the sorter group size (4/8/16/32);
//   - the number of real elements.
// Slots that receive no real element hold a pad value that sorts to the
// bottom: 0x80 for signed data, 0 for unsigned data.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_valid_i/ready  frame configuration handshake
//                      (cfg_sign_i, cfg_gsize_i, cfg_num_i)
//   in_valid_i/ready   element stream (in_data_i)
//   out_valid_o/ready  frame handoff to the sorter
//   out_data_o         parallel frame; element k is at bits [k*DATAWIDTH +: DATAWIDTH]
//   out_sign_o         latched signedness
//   out_ch*_o          per-sorter channel enables for the selected group size
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module topk_input_loader #(
  parameter int DATAWIDTH      = 8,
  parameter int MAX_DATALENGTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_valid_i,
  output logic                                cfg_ready_o,
  input  logic                                cfg_sign_i,
  input  logic [1:0]                          cfg_gsize_i,
  input  logic [5:0]                          cfg_num_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATAWIDTH-1:0]                in_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [MAX_DATALENGTH*DATAWIDTH-1:0] out_data_o,
  output logic                                out_sign_o,
  output logic [7:0]                          out_ch4_o,
  output logic [3:0]                          out_ch8_o,
  output logic [1:0]                          out_ch16_o,
  output logic                                out_ch32_o
);

  // Most negative two's-complement value, so signed pads sort last.
  localparam logic [DATAWIDTH-1:0] PAD_SIGNED = {1'b1, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

  state_t               state_reg, state_next;
  logic [5:0]           idx_reg;
  logic [5:0]           num_reg;
  logic                 sign_reg;
  logic [1:0]           gsize_reg;
  logic [7:0]           ch4_reg, ch4_next;
  logic [3:0]           ch8_reg, ch8_next;
  logic [1:0]           ch16_reg, ch16_next;
  logic                 ch32_reg, ch32_next;
  logic [5:0]           num_eff;
  logic [DATAWIDTH-1:0] pad_value;
  logic                 cfg_fire, in_fire, last_elem;

  // A count of zero, or a count larger than the buffer, means a full frame.
  always_comb begin
    num_eff = cfg_num_i;
    if (cfg_num_i == 6'd0 || cfg_num_i > 6'(MAX_DATALENGTH))
      num_eff = 6'(MAX_DATALENGTH);
  end

  assign pad_value = cfg_sign_i ? PAD_SIGNED : '0;
  assign cfg_fire  = cfg_valid_i && cfg_ready_o;
  assign in_fire   = in_valid_i && in_ready_o;
  // num_reg is at least 1 whenever LOAD is active, so the subtraction cannot wrap.
  assign last_elem = (idx_reg == num_reg - 6'd1);

  // Handshake outputs depend on the state alone.
  always_comb begin
    state_next  = state_reg;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_next = LOAD;
      end
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_elem) state_next = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel j of group size G is enabled when its first element j*G holds real data.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch4
      assign ch4_next[gi] = (gsize_reg == 2'd0) && (num_reg > 6'(gi * 4));
    end
    for (gi = 0; gi < 4; gi++) begin : g_ch8
      assign ch8_next[gi] = (gsize_reg == 2'd1) && (num_reg > 6'(gi * 8));
    end
    for (gi = 0; gi < 2; gi++) begin : g_ch16
      assign ch16_next[gi] = (gsize_reg == 2'd2) && (num_reg > 6'(gi * 16));
    end
  endgenerate
  assign ch32_next = (gsize_reg == 2'd3) && (num_reg != 6'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      num_reg   <= '0;
      sign_reg  <= 1'b0;
      gsize_reg <= '0;
      ch4_reg   <= '0;
      ch8_reg   <= '0;
      ch16_reg  <= '0;
      ch32_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cfg_fire) begin
        sign_reg  <= cfg_sign_i;
        gsize_reg <= cfg_gsize_i;
        num_reg   <= num_eff;
        idx_reg   <= '0;
      end
      if (in_fire) begin
        idx_reg <= idx_reg + 6'd1;
        // Enables are captured on entry to OUT so that they hold their last
        // values while the next frame's configuration is loading.
        if (last_elem) begin
          ch4_reg  <= ch4_next;
          ch8_reg  <= ch8_next;
          ch16_reg <= ch16_next;
          ch32_reg <= ch32_next;
        end
      end
    end
  end

  // Frame buffer: every slot is written in parallel, so it is built from
  // registers rather than RAM.
  generate
    for (gi = 0; gi < MAX_DATALENGTH; gi++) begin : g_slot
      logic [DATAWIDTH-1:0] slot_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i)
          slot_reg <= '0;
        else if (cfg_fire)
          slot_reg <= pad_value;
        else if (in_fire && idx_reg == 6'(gi))
          slot_reg <= in_data_i;
      end
      assign out_data_o[gi*DATAWIDTH +: DATAWIDTH] = slot_reg;
    end
  endgenerate

  assign out_sign_o = sign_reg;
  assign out_ch4_o  = ch4_reg;
  assign out_ch8_o  = ch8_reg;
  assign out_ch16_o = ch16_reg;
  assign out_ch32_o = ch32_reg;

endmodule

// File: tb/tb_topk_input_loader.sv
// -----------------------------------------------------------------------------
// tb_topk_input_loader
//
// Randomised, self-checking bench for topk_input_loader.
//
// For every configured frame, a reference model computes the expected
// frame from the configuration and the elements that were sent:
//   - the padded data;
//   - the sign;
//   - the channel masks.
// The expected frame is queued. A monitor compares the DUT outputs against
// the head of that queue on every cycle in which out_valid_o is high.
// Directed scenarios add literal expectations and cycle-exact handshake
// checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_topk_input_loader;

  logic         clk_i, rst_i;
  logic         cfg_valid_i, cfg_ready_o, cfg_sign_i;
  logic [1:0]   cfg_gsize_i;
  logic [5:0]   cfg_num_i;
  logic         in_valid_i, in_ready_o;
  logic [7:0]   in_data_i;
  logic         out_valid_o, out_ready_i;
  logic [255:0] out_data_o;
  logic         out_sign_o;
  logic [7:0]   out_ch4_o;
  logic [3:0]   out_ch8_o;
  logic [1:0]   out_ch16_o;
  logic         out_ch32_o;

  topk_input_loader #(.DATAWIDTH(8), .MAX_DATALENGTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_sign_i(cfg_sign_i),
    .cfg_gsize_i(cfg_gsize_i), .cfg_num_i(cfg_num_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_sign_o(out_sign_o), .out_ch4_o(out_ch4_o), .out_ch8_o(out_ch8_o),
    .out_ch16_o(out_ch16_o), .out_ch32_o(out_ch32_o)
  );

  typedef struct {
    logic [255:0] data;
    logic         sign;
    logic [7:0]   ch4;
    logic [3:0]   ch8;
    logic [1:0]   ch16;
    logic         ch32;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     ready_auto = 1'b1;
  bit     ready_force = 1'b0;
  int     ready_prob = 100;
  bit     tp_on = 1'b0;
  bit     have_prev = 1'b0;
  longint last_cfg_t = 0;
  int     last_neff = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink readiness: either random with a given probability, or forced.
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      out_ready_i = ready_auto ? ($urandom_range(0, 99) < ready_prob) : ready_force;
    end
  end

  // Compare the output frame against the model while it is meaningful.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && out_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 256'(out_valid_o), 256'(0));
        end else begin
          chk("out_data", out_data_o, exp_q[0].data);
          chk("out_sign", 256'(out_sign_o), 256'(exp_q[0].sign));
          chk("out_ch4", 256'(out_ch4_o), 256'(exp_q[0].ch4));
          chk("out_ch8", 256'(out_ch8_o), 256'(exp_q[0].ch8));
          chk("out_ch16", 256'(out_ch16_o), 256'(exp_q[0].ch16));
          chk("out_ch32", 256'(out_ch32_o), 256'(exp_q[0].ch32));
          chk("out_in_ready", 256'(in_ready_o), 256'(0));
          chk("out_cfg_ready", 256'(cfg_ready_o), 256'(0));
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Configure one frame and stream its elements.
  // Returns at the first negedge after the last element, or right after a
  // reset when abort_after >= 0.
  task automatic send_frame(input logic s, input logic [1:0] g, input logic [5:0] n,
                            input int vprob, input bit ramp, input int abort_after);
    int         neff, gsz, groups, k, guard;
    logic [7:0] elems[32];
    logic [31:0] mask;
    exp_t       e;
    bit         acc;
    longint     t;

    neff = (n == 6'd0 || n > 6'd32) ? 32 : int'(n);
    for (int i = 0; i < 32; i++) elems[i] = ramp ? 8'(i) : 8'($urandom);
    gsz    = 4 << g;
    groups = (neff + gsz - 1) / gsz;
    mask   = (32'd1 << groups) - 32'd1;
    e.ch4  = (g == 2'd0) ? mask[7:0] : 8'd0;
    e.ch8  = (g == 2'd1) ? mask[3:0] : 4'd0;
    e.ch16 = (g == 2'd2) ? mask[1:0] : 2'd0;
    e.ch32 = (g == 2'd3) ? mask[0]   : 1'b0;
    e.sign = s;
    for (int i = 0; i < 32; i++)
      e.data[i*8 +: 8] = (i < neff) ? elems[i] : (s ? 8'h80 : 8'h00);

    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b1; cfg_sign_i = s; cfg_gsize_i = g; cfg_num_i = n;
    guard = 0;
    while (1) begin
      @(negedge clk_i);
      if (cfg_ready_o) break;
      guard++;
      if (guard > 200) begin
        chk("cfg_timeout", 256'(0), 256'(1));
        cfg_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    exp_q.push_back(e);
    t = longint'($time);
    if (tp_on && have_prev) chk("throughput", 256'(t - last_cfg_t), 256'((last_neff + 2) * 10));
    have_prev  = 1'b1;
    last_cfg_t = t;
    last_neff  = neff;
    #1;
    cfg_valid_i = 1'b0;

    k = 0;
    guard = 0;
    while (k < neff) begin
      in_valid_i = ($urandom_range(0, 99) < vprob);
      in_data_i  = elems[k];
      // A configuration offered during LOAD must be ignored.
      cfg_valid_i = 1'($urandom_range(0, 1));
      cfg_sign_i  = 1'($urandom_range(0, 1));
      cfg_num_i   = 6'($urandom_range(0, 63));
      @(negedge clk_i);
      chk("load_in_ready", 256'(in_ready_o), 256'(1));
      chk("load_cfg_ready", 256'(cfg_ready_o), 256'(0));
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i);
      if (acc) k++;
      #1;
      if (abort_after >= 0 && k == abort_after) begin
        rst_i = 1'b1; in_valid_i = 1'b0; cfg_valid_i = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        return;
      end
      guard++;
      if (guard > 2000) begin
        chk("load_timeout", 256'(0), 256'(1));
        in_valid_i = 1'b0;
        cfg_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i  = 1'b0;
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("out_valid_after_last", 256'(out_valid_o), 256'(1));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cfg_ready"}, 256'(cfg_ready_o), 256'(1));
    chk({tag, "_in_ready"}, 256'(in_ready_o), 256'(0));
    chk({tag, "_out_valid"}, 256'(out_valid_o), 256'(0));
    chk({tag, "_sign"}, 256'(out_sign_o), 256'(0));
    chk({tag, "_channels"}, 256'({out_ch4_o, out_ch8_o, out_ch16_o, out_ch32_o}), 256'(0));
    chk({tag, "_data"}, out_data_o, 256'(0));
  endtask

  initial begin
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_sign_i = 1'b0; cfg_gsize_i = 2'd0;
    cfg_num_i = 6'd0; in_valid_i = 1'b0; in_data_i = 8'd0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_state("reset");

    // Unsigned ramp, group size 4, full frame; then back-to-back frames at full rate.
    tp_on = 1'b1;
    send_frame(1'b0, 2'd0, 6'd32, 100, 1'b1, -1);
    $display("frame ramp32 g4: ch4=%0h", out_ch4_o);
    chk("ramp_ch4", 256'(out_ch4_o), 256'(8'hFF));
    chk("ramp_other_ch", 256'({out_ch8_o, out_ch16_o, out_ch32_o}), 256'(0));
    chk("ramp_slot31", 256'(out_data_o[255:248]), 256'(8'd31));
    chk("ramp_slot5", 256'(out_data_o[47:40]), 256'(8'd5));

    send_frame(1'b1, 2'd1, 6'd10, 100, 1'b0, -1);
    $display("frame signed num10 g8: ch8=%0h", out_ch8_o);
    chk("signed_ch8", 256'(out_ch8_o), 256'(4'b0011));
    chk("signed_sign", 256'(out_sign_o), 256'(1));
    chk("signed_slot10", 256'(out_data_o[87:80]), 256'(8'h80));
    chk("signed_slot31", 256'(out_data_o[255:248]), 256'(8'h80));

    send_frame(1'b0, 2'd3, 6'd0, 100, 1'b0, -1);
    $display("frame num0 g32: ch32=%0d", out_ch32_o);
    chk("num0_ch32", 256'(out_ch32_o), 256'(1));
    send_frame(1'b1, 2'd3, 6'd40, 100, 1'b0, -1);
    $display("frame num40 g32: ch32=%0d", out_ch32_o);
    chk("num40_ch32", 256'(out_ch32_o), 256'(1));
    tp_on = 1'b0;
    have_prev = 1'b0;

    // Back-pressure in OUT; stray inputs and a new cfg must be ignored.
    ready_auto = 1'b0;
    ready_force = 1'b0;
    send_frame(1'b0, 2'd2, 6'd12, 100, 1'b0, -1);
    in_valid_i = 1'b1; in_data_i = 8'hEE;
    cfg_valid_i = 1'b1; cfg_num_i = 6'd5; cfg_sign_i = 1'b1; cfg_gsize_i = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_out_valid", 256'(out_valid_o), 256'(1));
    end
    ready_force = 1'b1;
    @(negedge clk_i);
    chk("stall_release_valid", 256'(out_valid_o), 256'(1));
    ready_force = 1'b0;
    @(negedge clk_i);
    $display("stall handoff done: out_valid=%0d cfg_ready=%0d", out_valid_o, cfg_ready_o);
    chk("post_handoff_out_valid", 256'(out_valid_o), 256'(0));
    chk("post_handoff_cfg_ready", 256'(cfg_ready_o), 256'(1));
    chk("post_handoff_in_ready", 256'(in_ready_o), 256'(0));
    cfg_valid_i = 1'b0;
    in_valid_i = 1'b0;
    ready_auto = 1'b1;

    // Bursty element stream.
    ready_prob = 60;
    send_frame(1'b0, 2'd2, 6'd16, 50, 1'b0, -1);
    $display("frame bursty num16 g16: ch16=%0h", out_ch16_o);
    chk("bursty_ch16", 256'(out_ch16_o), 256'(2'b01));

    // Reset in the middle of a frame, then a short unsigned frame.
    send_frame(1'b0, 2'd1, 6'd20, 80, 1'b0, 7);
    @(negedge clk_i);
    $display("aborted frame after 7 elements");
    chk_reset_state("abort");
    repeat (3) begin
      @(negedge clk_i);
      chk("abort_no_out_valid", 256'(out_valid_o), 256'(0));
    end
    ready_prob = 100;
    send_frame(1'b0, 2'd0, 6'd4, 100, 1'b0, -1);
    $display("frame num4 g4: ch4=%0h", out_ch4_o);
    chk("num4_pad_zero", 256'(out_data_o[255:32]), 256'(0));
    chk("num4_ch4", 256'(out_ch4_o), 256'(8'h01));

    // Random frames.
    ready_prob = 50;
    for (int f = 0; f < 20; f++) begin
      send_frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, 63)), $urandom_range(30, 100), 1'b0, -1);
      $display("random frame %0d: sign=%0d ch=%0h/%0h/%0h/%0h", f, out_sign_o,
               out_ch4_o, out_ch8_o, out_ch16_o, out_ch32_o);
    end

    ready_prob = 100;
    repeat (5) @(negedge clk_i);
    chk("drain", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/topk_input_loader.md
TOPK_INPUT_LOADER -- requirements
Module: topk_input_loader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning element width in bits.
REQ-002 SHALL have parameter MAX_DATALENGTH, default 32, meaning frame capacity in elements.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports cfg_valid_i (input, 1) and cfg_ready_o (output, 1): frame configuration handshake.
REQ-006 SHALL have port cfg_sign_i, input, 1, 1 = signed elements, 0 = unsigned.
REQ-007 SHALL have port cfg_gsize_i, input, 2, group size select: 0 = 4, 1 = 8, 2 = 16, 3 = 32.
REQ-008 SHALL have port cfg_num_i, input, 6, number of real elements in the frame.
REQ-009 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1) and in_data_i (input, DATAWIDTH): element stream.
REQ-010 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): frame handoff handshake to the sorter top.
REQ-011 SHALL have port out_data_o, output, MAX_DATALENGTH x DATAWIDTH, the parallel frame, index 0 = first element received.
REQ-012 SHALL have port out_sign_o, output, 1, the latched cfg_sign_i.
REQ-013 SHALL have ports out_ch4_o (8), out_ch8_o (4), out_ch16_o (2) and out_ch32_o (1), all outputs: per-sorter channel enables.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and OUT.
REQ-015 SHALL drive, per state: IDLE cfg_ready_o=1; LOAD in_ready_o=1; OUT out_valid_o=1; every other handshake output 0.
REQ-016 SHALL compute num_eff = 32 when cfg_num_i is 0 or greater than 32, otherwise num_eff = cfg_num_i.
REQ-017 SHALL, on a cfg handshake in IDLE, latch sign, group size and num_eff, set every buffer slot to the pad value and enter LOAD.
REQ-018 SHALL use pad value 0x80 when signed and 0x00 when unsigned, so pads sort to the bottom.
REQ-019 SHALL, on each in handshake in LOAD, write in_data_i to slot idx and increment idx, where idx starts at 0.
REQ-020 SHALL, when the accepted element has idx = num_eff-1, enter OUT, with out_valid_o high in the next cycle.
REQ-021 SHALL, in LOAD with in_valid_i=0, hold state and idx unchanged.
REQ-022 SHALL, for the selected group size G, set channel bit j to 1 iff j*G < num_eff.
REQ-023 SHALL drive every channel bit of the non-selected group sizes to 0.
REQ-024 SHALL hold out_data_o, out_sign_o and all channel outputs stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL, on out handshake, return to IDLE; a new cfg SHALL NOT be accepted in the same cycle.
REQ-026 SHALL give throughput of one frame per num_eff+2 cycles when cfg_valid_i, in_valid_i and out_ready_i are held high.
REQ-027 SHALL ignore in_valid_i in IDLE and OUT, and cfg_valid_i in LOAD and OUT; no side effects.
REQ-028 SHALL keep out_data_o and channel outputs at their last values outside OUT; they are only meaningful while out_valid_o=1.

Reset
REQ-029 SHALL, with rst_i high at a clock edge, enter IDLE, clear idx, clear all buffer slots to 0 and clear all latched config.
REQ-030 SHALL, after reset, drive cfg_ready_o=1, in_ready_o=0, out_valid_o=0, out_sign_o=0, all channel bits 0 and out_data_o all 0.
REQ-031 SHALL, on rst_i asserted in LOAD or OUT, discard the partial or pending frame, with no out handshake following.

Verification
REQ-032 SHALL test: unsigned, gsize=0, num=32, data 0..31, out_ready=1 -> out_data_o[k]=k, out_ch4_o=0xFF, other channels 0, out_valid_o 1 cycle after element 31.
REQ-033 SHALL test: signed, gsize=1, num=10 -> slots 10..31 = 0x80, out_ch8_o=0b0011, out_sign_o=1.
REQ-034 SHALL test: gsize=3 with num=0 and num=40 -> num_eff=32, out_ch32_o=1, 32 elements accepted.
REQ-035 SHALL test: out_ready_i low 5 cycles in OUT -> outputs stable, in_ready_o=0, cfg_ready_o=0, IDLE the cycle after the handshake.
REQ-036 SHALL test: in_valid_i toggling randomly with num=16, gsize=2 -> in order, out_ch16_o=0b01, no element lost or duplicated.
REQ-037 SHALL test: rst_i pulsed after 7 of 20 elements -> IDLE, out_valid_o never asserted; next frame num=4 unsigned -> slots 4..31 = 0x00.
